// File: rtl/ctrl_pkg.sv
// Shared control definitions: instruction kinds, opcode prefixes, halt word
// and the encoder's state type. The control decoder imports the same package.
package ctrl_pkg;

   typedef enum logic [2:0] {
      KIND_ALU    = 3'd0,
      KIND_BRANCH = 3'd1,
      KIND_LOADR  = 3'd2,
      KIND_LOADC  = 3'd3,
      KIND_STORE  = 3'd4,
      KIND_MOVE   = 3'd5
   } instr_kind_t;

   localparam logic [2:0] OP_BR  = 3'b100;
   localparam logic [2:0] OP_ST  = 3'b101;
   localparam logic [2:0] OP_LD  = 3'b110;
   localparam logic [2:0] OP_MOV = 3'b111;

   // ALU form with aluop=3, ra=3, rb=7; reserved as the program terminator.
   localparam logic [8:0] HALT_WORD = 9'b011111111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_DONE = 2'd3
   } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns one instruction tuple into its 9-bit
// machine word and flags tuples that have no legal encoding.
module instr_pack
   import ctrl_pkg::*;
(
   input  logic [2:0] kind,
   input  logic [2:0] aluop,
   input  logic [2:0] ra,
   input  logic [2:0] rb,
   input  logic [5:0] imm,
   output logic [8:0] word,
   output logic       illegal
);

   // Select the encoding for the kind and detect unencodable field values.
   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (kind)
         KIND_ALU: begin
            word = {1'b0, aluop, ra[1:0], rb};
            // Only r0..r3 fit in the ra slot, and the halt pattern is reserved.
            if (ra[2] || ({aluop, ra, rb} == 9'b011_011_111)) begin
               illegal = 1'b1;
            end
         end
         KIND_BRANCH: word = {OP_BR, imm};
         KIND_LOADR:  word = {OP_LD, rb, 2'b00, 1'b0};
         KIND_LOADC: begin
            word = {OP_LD, imm[4:0], 1'b1};
            if (imm[5]) begin
               illegal = 1'b1;
            end
         end
         KIND_STORE:  word = {OP_ST, rb, 3'b000};
         KIND_MOVE:   word = {OP_MOV, ra, rb};
         default:     illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program-building encoder: accepts instruction tuples, writes their machine
// words to consecutive instruction memory addresses and optionally appends
// the halt word. The 9-bit address register doubles as the full flag: bit 8
// sets once address 255 has been written, so the counter can never wrap.
module instr_encoder
   import ctrl_pkg::*;
#(
   parameter logic [7:0] START_ADDR  = 8'd0,
   parameter bit         APPEND_HALT = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_kind,
   input  logic [2:0] in_aluop,
   input  logic [2:0] in_ra,
   input  logic [2:0] in_rb,
   input  logic [5:0] in_imm,
   input  logic       in_last,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] count
);

   enc_state_t state_reg, state_next;
   logic [8:0] addr_reg, addr_next;
   logic       wr_en_reg, wr_en_next;
   logic [7:0] wr_addr_reg, wr_addr_next;
   logic [8:0] wr_data_reg, wr_data_next;
   logic [7:0] count_reg, count_next;
   logic       err_reg, err_next;

   logic [8:0] pack_word;
   logic       pack_illegal;
   logic       accept;

   instr_pack u_pack (
      .kind    (in_kind),
      .aluop   (in_aluop),
      .ra      (in_ra),
      .rb      (in_rb),
      .imm     (in_imm),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

   assign in_ready = (state_reg == ST_RUN) && !addr_reg[8];
   assign accept   = in_ready && in_valid;

   // Next-state, address/count and write-port logic.
   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      wr_en_next   = 1'b0;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;
      count_next   = count_reg;
      err_next     = err_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = ST_RUN;
               addr_next  = {1'b0, START_ADDR};
               count_next = '0;
               err_next   = 1'b0;
            end
         end
         ST_RUN: begin
            if (addr_reg[8]) begin
               err_next   = 1'b1;
               state_next = ST_DONE;
            end else if (accept) begin
               if (pack_illegal) begin
                  err_next = 1'b1;
               end else begin
                  wr_en_next   = 1'b1;
                  wr_addr_next = addr_reg[7:0];
                  wr_data_next = pack_word;
                  addr_next    = addr_reg + 9'd1;
                  count_next   = count_reg + 8'd1;
               end
               if (in_last) begin
                  state_next = APPEND_HALT ? ST_HALT : ST_DONE;
               end else if (!pack_illegal && (addr_reg[7:0] == 8'hFF)) begin
                  // Memory filled before the program ended.
                  err_next   = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_HALT: begin
            state_next = ST_DONE;
            if (addr_reg[8]) begin
               err_next = 1'b1;
            end else begin
               wr_en_next   = 1'b1;
               wr_addr_next = addr_reg[7:0];
               wr_data_next = HALT_WORD;
               addr_next    = addr_reg + 9'd1;
               count_next   = count_reg + 8'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops any pending write.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg   <= ST_IDLE;
         addr_reg    <= '0;
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         count_reg   <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         wr_en_reg   <= wr_en_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= wr_data_next;
         count_reg   <= count_next;
         err_reg     <= err_next;
      end
   end

   assign wr_en   = wr_en_reg;
   assign wr_addr = wr_addr_reg;
   assign wr_data = wr_data_reg;
   assign count   = count_reg;
   assign err     = err_reg;
   assign busy    = (state_reg == ST_RUN) || (state_reg == ST_HALT);
   assign done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (start address 0 and 254) share one
// stimulus stream; a behavioural model predicts every output each cycle and
// literal expectations pin the written program images.
module tb_instr_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] in_kind = '0;
   logic [2:0] in_aluop = '0;
   logic [2:0] in_ra = '0;
   logic [2:0] in_rb = '0;
   logic [5:0] in_imm = '0;
   logic       in_last = 1'b0;

   logic       in_ready_w [2];
   logic       wr_en_w    [2];
   logic [7:0] wr_addr_w  [2];
   logic [8:0] wr_data_w  [2];
   logic       busy_w     [2];
   logic       done_w     [2];
   logic       err_w      [2];
   logic [7:0] count_w    [2];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_rec_t;
   wr_rec_t q0[$];
   wr_rec_t q1[$];

   always #5 clk = ~clk;

   instr_encoder #(.START_ADDR(8'd0), .APPEND_HALT(1'b1)) dut0 (
      .Clk(clk), .Reset(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready_w[0]), .in_kind(in_kind), .in_aluop(in_aluop),
      .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
      .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .count(count_w[0])
   );

   instr_encoder #(.START_ADDR(8'd254), .APPEND_HALT(1'b1)) dut1 (
      .Clk(clk), .Reset(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready_w[1]), .in_kind(in_kind), .in_aluop(in_aluop),
      .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
      .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .count(count_w[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Machine word as a number, or -1 when the tuple cannot be encoded.
   function automatic int encode(input int kind, input int aluop, input int ra,
                                 input int rb, input int imm);
      case (kind)
         0: return (ra > 3 || (aluop == 3 && ra == 3 && rb == 7)) ? -1
                   : aluop * 32 + ra * 8 + rb;
         1: return 256 + imm;
         2: return 384 + rb * 8;
         3: return (imm > 31) ? -1 : 384 + imm * 2 + 1;
         4: return 320 + rb * 8;
         5: return 448 + ra * 8 + rb;
         default: return -1;
      endcase
   endfunction

   // Behavioural model, one slot per instance.
   int sa [2] = '{0, 254};
   bit m_run  [2] = '{0, 0};
   bit m_halt [2] = '{0, 0};
   bit m_done [2] = '{0, 0};
   bit m_err  [2] = '{0, 0};
   bit m_wr_en[2] = '{0, 0};
   int m_addr [2] = '{0, 0};
   int m_count[2] = '{0, 0};
   int m_wr_addr[2] = '{0, 0};
   int m_wr_data[2] = '{0, 0};

   initial begin
      int w;
      forever begin
         @(posedge clk or posedge rst);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               m_run[d] = 0; m_halt[d] = 0; m_done[d] = 0; m_err[d] = 0;
               m_wr_en[d] = 0; m_addr[d] = 0; m_count[d] = 0;
            end else begin
               m_wr_en[d] = 0;
               if (m_run[d]) begin
                  if (in_valid && m_addr[d] < 256) begin
                     w = encode(int'(in_kind), int'(in_aluop), int'(in_ra),
                                int'(in_rb), int'(in_imm));
                     if (w < 0) m_err[d] = 1;
                     else begin
                        m_wr_en[d] = 1; m_wr_addr[d] = m_addr[d]; m_wr_data[d] = w;
                        m_addr[d]++; m_count[d]++;
                     end
                     if (in_last) begin
                        m_run[d] = 0; m_halt[d] = 1;
                     end else if (w >= 0 && m_addr[d] == 256) begin
                        m_run[d] = 0; m_done[d] = 1; m_err[d] = 1;
                     end
                  end
               end else if (m_halt[d]) begin
                  m_halt[d] = 0; m_done[d] = 1;
                  if (m_addr[d] < 256) begin
                     m_wr_en[d] = 1; m_wr_addr[d] = m_addr[d]; m_wr_data[d] = 9'h0FF;
                     m_addr[d]++; m_count[d]++;
                  end else m_err[d] = 1;
               end else if (start) begin
                  m_run[d] = 1; m_done[d] = 0; m_addr[d] = sa[d];
                  m_count[d] = 0; m_err[d] = 0;
               end
            end
         end
      end
   end

   // Per-cycle compare against the model and write logging.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d in_ready", d), int'(in_ready_w[d]),
                int'(m_run[d] && m_addr[d] < 256));
            chk($sformatf("d%0d wr_en", d), int'(wr_en_w[d]), int'(m_wr_en[d]));
            chk($sformatf("d%0d busy", d), int'(busy_w[d]), int'(m_run[d] || m_halt[d]));
            chk($sformatf("d%0d done", d), int'(done_w[d]), int'(m_done[d]));
            chk($sformatf("d%0d err", d), int'(err_w[d]), int'(m_err[d]));
            chk($sformatf("d%0d count", d), int'(count_w[d]), m_count[d] % 256);
            if (m_wr_en[d]) begin
               chk($sformatf("d%0d wr_addr", d), int'(wr_addr_w[d]), m_wr_addr[d]);
               chk($sformatf("d%0d wr_data", d), int'(wr_data_w[d]), m_wr_data[d]);
            end
            if (wr_en_w[d] === 1'b1) begin
               if (d == 0) q0.push_back('{cyc, int'(wr_addr_w[0]), int'(wr_data_w[0])});
               else        q1.push_back('{cyc, int'(wr_addr_w[1]), int'(wr_data_w[1])});
               $display("t=%0t dut%0d write addr=%0d data=%03h", $time, d,
                        wr_addr_w[d], wr_data_w[d]);
            end
         end
      end
   end

   task automatic drive(input int kind, input int aluop, input int ra,
                        input int rb, input int imm, input bit last);
      in_kind = 3'(kind); in_aluop = 3'(aluop); in_ra = 3'(ra);
      in_rb = 3'(rb); in_imm = 6'(imm); in_last = last; in_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; in_last = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      q0.delete(); q1.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_wr(input string name, input int d, input int i,
                         input int addr, input int data);
      if (d == 0) begin
         chk({name, " size"}, q0.size() > i, 1);
         if (q0.size() > i) begin
            chk({name, " addr"}, q0[i].addr, addr);
            chk({name, " data"}, q0[i].data, data);
         end
      end else begin
         chk({name, " size"}, q1.size() > i, 1);
         if (q1.size() > i) begin
            chk({name, " addr"}, q1[i].addr, addr);
            chk({name, " data"}, q1[i].data, data);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("reset done", int'(done_w[0]), 0);
      chk("reset wr_en", int'(wr_en_w[0]), 0);
      chk("reset count", int'(count_w[0]), 0);
      chk("reset in_ready", int'(in_ready_w[0]), 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic program with appended halt.
      pulse_start();
      drive(0, 2, 1, 5, 0, 0);
      drive(1, 0, 0, 0, 6'h2A, 1);
      idle(3);
      #1;
      chk("t1 nwr", q0.size(), 3);
      chk_wr("t1 w0", 0, 0, 0, 9'h04D);
      chk_wr("t1 w1", 0, 1, 1, 9'h12A);
      chk_wr("t1 w2", 0, 2, 2, 9'h0FF);
      chk("t1 done", int'(done_w[0]), 1);
      chk("t1 count", int'(count_w[0]), 3);
      chk("t1 err", int'(err_w[0]), 0);

      // Back-to-back kinds on consecutive cycles.
      pulse_start();
      drive(3, 0, 0, 0, 6'h13, 0);
      drive(2, 0, 0, 4, 0, 0);
      drive(4, 0, 0, 2, 0, 0);
      drive(5, 0, 3, 6, 0, 1);
      idle(3);
      #1;
      chk("t2 nwr", q0.size(), 5);
      chk_wr("t2 w0", 0, 0, 0, 9'h1A7);
      chk_wr("t2 w1", 0, 1, 1, 9'h1A0);
      chk_wr("t2 w2", 0, 2, 2, 9'h150);
      chk_wr("t2 w3", 0, 3, 3, 9'h1DE);
      chk_wr("t2 w4", 0, 4, 4, 9'h0FF);
      if (q0.size() == 5) begin
         for (int i = 1; i < 5; i++) chk("t2 consecutive", q0[i].cyc - q0[i-1].cyc, 1);
      end

      // Illegal tuples: only the halt word lands.
      pulse_start();
      drive(0, 0, 5, 0, 0, 0);
      drive(3, 0, 0, 0, 6'h20, 0);
      drive(7, 0, 0, 0, 0, 0);
      drive(0, 3, 3, 7, 0, 1);
      idle(3);
      #1;
      chk("t3 nwr", q0.size(), 1);
      chk_wr("t3 w0", 0, 0, 0, 9'h0FF);
      chk("t3 err", int'(err_w[0]), 1);
      chk("t3 count", int'(count_w[0]), 1);

      // Fill to address 255 on the 254-based instance.
      pulse_start();
      drive(1, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 2, 0);
      drive(1, 0, 0, 0, 3, 1);
      idle(3);
      #1;
      chk("t4 nwr", q1.size(), 2);
      chk_wr("t4 w0", 1, 0, 254, 9'h101);
      chk_wr("t4 w1", 1, 1, 255, 9'h102);
      chk("t4 err", int'(err_w[1]), 1);
      chk("t4 done", int'(done_w[1]), 1);
      chk("t4 count", int'(count_w[1]), 2);

      // Reset right after an accept.
      pulse_start();
      in_kind = 3'd5; in_ra = 3'd1; in_rb = 3'd1; in_last = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("t5 nwr", q0.size(), 0);
      chk("t5 wr_en", int'(wr_en_w[0]), 0);
      chk("t5 wr_addr", int'(wr_addr_w[0]), 0);
      chk("t5 wr_data", int'(wr_data_w[0]), 0);
      chk("t5 busy", int'(busy_w[0]), 0);
      chk("t5 count", int'(count_w[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      pulse_start();
      drive(5, 0, 1, 2, 0, 1);
      idle(3);
      #1;
      chk("t5 nwr2", q0.size(), 2);
      chk_wr("t5 w0", 0, 0, 0, 9'h1CA);
      chk_wr("t5 w1", 0, 1, 1, 9'h0FF);

      // Stalls, ignored in_valid outside RUN, start during RUN.
      drive(4, 0, 0, 1, 0, 0);
      idle(1);
      pulse_start();
      drive(0, 1, 2, 3, 0, 0);
      idle(1);
      start = 1'b1;
      drive(4, 0, 0, 7, 0, 0);
      start = 1'b0;
      idle(2);
      drive(1, 0, 0, 0, 6'h3F, 1);
      idle(3);
      #1;
      chk("t6 nwr", q0.size(), 4);
      chk_wr("t6 w0", 0, 0, 0, 9'h033);
      chk_wr("t6 w1", 0, 1, 1, 9'h178);
      chk_wr("t6 w2", 0, 2, 2, 9'h13F);
      chk_wr("t6 w3", 0, 3, 3, 9'h0FF);
      chk("t6 count", int'(count_w[0]), 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
